// File: rtl/c1541_gcr_stream_if.sv
// rtl/c1541_gcr_stream_if.sv - track-buffer RAM bus between the GCR stream engine and the buffer
interface c1541_gcr_stream_if #(
  parameter int ADDR_W = 13
);
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_do;
  logic [7:0]        ram_di;
  logic              ram_we;
  logic              ram_ready;

  modport master (output ram_addr, ram_di, ram_we, input ram_do, ram_ready);
  modport slave  (input ram_addr, ram_di, ram_we, output ram_do, ram_ready);
endinterface

// File: rtl/c1541_gcr_stream.sv
// rtl/c1541_gcr_stream.sv - 1541 GCR bit stream engine between the track buffer and drive logic
module c1541_gcr_stream #(
  parameter int ADDR_W    = 13,
  parameter int BASE_DIV  = 104,
  parameter int STEP_DIV  = 8,
  parameter int SYNC_ONES = 10,
  parameter int PULSE_W   = 16
) (
  input  logic               clk32,
  input  logic               reset,
  input  logic               mtr,
  input  logic               mode,
  input  logic [1:0]         speed_zone,
  input  logic [ADDR_W-1:0]  track_len,
  input  logic [7:0]         din,
  output logic [7:0]         dout,
  output logic               sync_n,
  output logic               byte_n,
  c1541_gcr_stream_if.master ram
);
  localparam int CNT_W  = $clog2(BASE_DIV + 3 * STEP_DIV + 1);
  localparam int PCNT_W = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_PULSE} pulse_state_t;

  pulse_state_t      state, state_nx;
  logic [CNT_W-1:0]  cnt, period, p_new;
  logic [2:0]        bit_idx, frame_cnt;
  logic [7:0]        rx, tx;
  logic [3:0]        ones, ones_next;
  logic              framed, mode_q, wr_pend;
  logic [PCNT_W-1:0] pcnt;
  logic              run, tick, mode_chg, rd_bit;
  logic              sync_now, sync_next, rd_start, rd_load, wr_done, byte_done;
  logic [ADDR_W-1:0] last_addr, addr_next;

  assign p_new    = CNT_W'(BASE_DIV) + CNT_W'(STEP_DIV) * CNT_W'(speed_zone);
  assign run      = mtr & ram.ram_ready;
  assign mode_chg = mode ^ mode_q;
  assign tick     = run & ~mode_chg & (cnt == period - CNT_W'(1));

  assign rd_bit    = ram.ram_do[3'd7 - bit_idx];
  assign ones_next = !rd_bit ? 4'd0 : (ones == 4'd15) ? ones : ones + 4'd1;
  assign sync_now  = (ones >= 4'(SYNC_ONES));
  assign sync_next = rd_bit & (ones_next >= 4'(SYNC_ONES));
  // First 0 after a SYNC run: that bit becomes bit 0 of a freshly framed byte
  assign rd_start  = sync_now & ~rd_bit;
  assign rd_load   = tick & mode & framed & ~sync_next & ~rd_start & (frame_cnt == 3'd7);
  assign wr_done   = tick & ~mode & (bit_idx == 3'd7);
  assign byte_done = rd_load | wr_done;

  // Wrap on >= so a track_len shrunk below the current address still wraps
  assign last_addr = (track_len == '0) ? '0 : track_len - ADDR_W'(1);
  assign addr_next = (ram.ram_addr >= last_addr) ? '0 : ram.ram_addr + ADDR_W'(1);

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      period       <= CNT_W'(BASE_DIV);
      bit_idx      <= '0;
      frame_cnt    <= '0;
      rx           <= '0;
      tx           <= '0;
      ones         <= '0;
      framed       <= 1'b0;
      mode_q       <= 1'b1;
      wr_pend      <= 1'b0;
      dout         <= '0;
      sync_n       <= 1'b1;
      ram.ram_addr <= '0;
      ram.ram_di   <= '0;
      ram.ram_we   <= 1'b0;
    end else begin
      mode_q     <= mode;
      ram.ram_we <= 1'b0;
      if (wr_pend) begin
        ram.ram_addr <= addr_next;
        wr_pend      <= 1'b0;
      end
      // New zone period is picked up only at a counter wrap (or while idle)
      if (cnt == '0)
        period <= p_new;
      if (mode_chg) begin
        cnt       <= '0;
        bit_idx   <= '0;
        frame_cnt <= '0;
        rx        <= '0;
        tx        <= '0;
        ones      <= '0;
        framed    <= 1'b0;
        sync_n    <= 1'b1;
      end else if (!run) begin
        cnt <= '0;
        if (!mtr)
          sync_n <= 1'b1;
      end else if (!tick) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt     <= '0;
        bit_idx <= bit_idx + 3'd1;
        if (mode) begin
          rx     <= {rx[6:0], rd_bit};
          ones   <= ones_next;
          sync_n <= ~sync_next;
          if (sync_next) begin
            frame_cnt <= '0;
          end else if (rd_start) begin
            framed    <= 1'b1;
            frame_cnt <= 3'd1;
          end else if (framed) begin
            frame_cnt <= frame_cnt + 3'd1;
            if (frame_cnt == 3'd7)
              dout <= {rx[6:0], rd_bit};
          end
          if (bit_idx == 3'd7)
            ram.ram_addr <= addr_next;
        end else begin
          if (bit_idx == 3'd0)
            tx <= din;
          // Write lands at the current address; the advance follows one clock later
          if (bit_idx == 3'd7) begin
            ram.ram_di <= tx;
            ram.ram_we <= 1'b1;
            wr_pend    <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (byte_done) state_nx = S_PEND;
      S_PEND:  state_nx = S_PULSE;
      S_PULSE: begin
        if (byte_done)
          state_nx = S_PEND;
        else if (pcnt == '0)
          state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (mode_chg || !mtr)
      state_nx = S_IDLE;
  end

  always_comb begin
    byte_n = 1'b1;
    if (state == S_PULSE)
      byte_n = 1'b0;
  end

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset)
      pcnt <= '0;
    else if (state == S_PEND)
      pcnt <= PCNT_W'(PULSE_W - 1);
    else if (state == S_PULSE && pcnt != '0)
      pcnt <= pcnt - PCNT_W'(1);
  end
endmodule

// File: tb/tb_c1541_gcr_stream.sv
// tb/tb_c1541_gcr_stream.sv - directed self-checking bench for c1541_gcr_stream
module tb_c1541_gcr_stream;
  localparam int P0 = 104;
  localparam int PW = 16;

  logic        clk32 = 1'b0;
  logic        reset = 1'b1;
  logic        mtr = 1'b0;
  logic        mode = 1'b1;
  logic        ready = 1'b1;
  logic        load = 1'b0;
  logic [1:0]  speed_zone = 2'd0;
  logic [12:0] track_len = 13'd8;
  logic [7:0]  din = 8'h00;
  logic [7:0]  dout;
  logic        sync_n, byte_n;
  logic [7:0]  mem [0:15];
  logic [7:0]  load_buf [0:15];
  int          n_cmp = 0;
  int          n_bad = 0;

  c1541_gcr_stream_if #(.ADDR_W(13)) bus ();

  c1541_gcr_stream dut (
    .clk32      (clk32),
    .reset      (reset),
    .mtr        (mtr),
    .mode       (mode),
    .speed_zone (speed_zone),
    .track_len  (track_len),
    .din        (din),
    .dout       (dout),
    .sync_n     (sync_n),
    .byte_n     (byte_n),
    .ram        (bus)
  );

  always #5 clk32 = ~clk32;

  assign bus.ram_do    = mem[bus.ram_addr[3:0]];
  assign bus.ram_ready = ready;

  always @(posedge clk32) begin
    if (load) begin
      for (int i = 0; i < 16; i++) mem[i] <= load_buf[i];
    end else if (bus.ram_we) begin
      mem[bus.ram_addr[3:0]] <= bus.ram_di;
    end
  end

  typedef struct {
    logic [1:0] zone;
    int         period;
    logic [7:0] d0, d1, d2;
  } row_t;
  row_t rows [4];

  int         cyc, t_sync, t_a1, t_a2, t_b0, w0, nb, na, nbn, nsl, nwe, we_hi, chg;
  logic [7:0] dv [3];
  int         aseq [4];
  int         we_t [2], we_a [2], we_d [2];
  logic       prev_bn, prev_sn, prev_we;
  logic [12:0] prev_addr, a_frz;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic set_buf8(input logic [63:0] v);
    for (int i = 0; i < 16; i++) load_buf[i] = (i < 8) ? v[63 - 8*i -: 8] : 8'h00;
  endtask

  task automatic start_read(input logic [1:0] zone, input logic [12:0] tl);
    reset = 1'b1;
    mtr = 1'b0;
    mode = 1'b1;
    speed_zone = zone;
    track_len = tl;
    din = 8'h00;
    load = 1'b1;
    @(negedge clk32);
    load = 1'b0;
    @(negedge clk32);
    reset = 1'b0;
    @(negedge clk32);
    mtr = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dout"},   int'(dout), 0);
    check({tag, "_sync_n"}, int'(sync_n), 1);
    check({tag, "_byte_n"}, int'(byte_n), 1);
    check({tag, "_addr"},   int'(bus.ram_addr), 0);
    check({tag, "_di"},     int'(bus.ram_di), 0);
    check({tag, "_we"},     int'(bus.ram_we), 0);
  endtask

  initial begin
    rows[0] = '{zone: 2'd0, period: 104, d0: 8'h52, d1: 8'h55, d2: 8'hAA};
    rows[1] = '{zone: 2'd1, period: 112, d0: 8'h52, d1: 8'h55, d2: 8'hAA};
    rows[2] = '{zone: 2'd2, period: 120, d0: 8'h52, d1: 8'h55, d2: 8'hAA};
    rows[3] = '{zone: 2'd3, period: 128, d0: 8'h52, d1: 8'h55, d2: 8'hAA};

    set_buf8(64'h0000_0000_0000_0000);
    load = 1'b1;
    repeat (2) @(negedge clk32);
    load = 1'b0;
    check_reset_outputs("reset");

    // Read with a SYNC-headed buffer in every zone
    for (int r = 0; r < 4; r++) begin
      set_buf8(64'hFFFF_5255_AA96_690F);
      start_read(rows[r].zone, 13'd8);
      cyc = 0; t_sync = -1; t_a1 = -1; t_a2 = -1; t_b0 = -1; w0 = -1; nb = 0;
      prev_bn = byte_n; prev_sn = sync_n; prev_addr = bus.ram_addr;
      while (cyc < 8000 && nb < 3) begin
        @(negedge clk32);
        cyc++;
        if (prev_sn && !sync_n && t_sync < 0) t_sync = cyc;
        if (bus.ram_addr != prev_addr) begin
          if (t_a1 < 0) t_a1 = cyc;
          else if (t_a2 < 0) t_a2 = cyc;
        end
        if (prev_bn && !byte_n) begin
          if (nb == 0) t_b0 = cyc;
          dv[nb] = dout;
          nb++;
        end
        if (!prev_bn && byte_n && w0 < 0) w0 = cyc - t_b0;
        prev_bn = byte_n; prev_sn = sync_n; prev_addr = bus.ram_addr;
      end
      check($sformatf("z%0d_nbytes", r), nb, 3);
      check($sformatf("z%0d_dout0", r), int'(dv[0]), int'(rows[r].d0));
      check($sformatf("z%0d_dout1", r), int'(dv[1]), int'(rows[r].d1));
      check($sformatf("z%0d_dout2", r), int'(dv[2]), int'(rows[r].d2));
      check($sformatf("z%0d_byte_clks", r), t_a2 - t_a1, 8 * rows[r].period);
      check($sformatf("z%0d_sync_to_byte", r), t_b0 - t_sync, 14 * rows[r].period + 1);
      check($sformatf("z%0d_pulse_w", r), w0, PW);
    end

    // No SYNC, track_len=4: address wraps 3 -> 0 and no byte strobes
    set_buf8(64'h5555_5555_5555_5555);
    start_read(2'd0, 13'd4);
    cyc = 0; na = 0; nbn = 0; nsl = 0;
    prev_addr = bus.ram_addr;
    while (cyc < 5 * 8 * P0 && na < 4) begin
      @(negedge clk32);
      cyc++;
      if (bus.ram_addr != prev_addr) begin
        aseq[na] = int'(bus.ram_addr);
        na++;
      end
      if (!byte_n) nbn++;
      if (!sync_n) nsl++;
      prev_addr = bus.ram_addr;
    end
    check("wrap_count", na, 4);
    check("wrap_a1", aseq[0], 1);
    check("wrap_a2", aseq[1], 2);
    check("wrap_a3", aseq[2], 3);
    check("wrap_a4", aseq[3], 0);
    check("nosync_byte_n_low", nbn, 0);
    check("nosync_sync_low", nsl, 0);

    // Reach address 2, then switch to write mode with din=A5
    cyc = 0;
    while (cyc < 3 * 8 * P0 && bus.ram_addr != 13'd2) begin
      @(negedge clk32);
      cyc++;
    end
    check("reach_addr2", int'(bus.ram_addr), 2);
    mode = 1'b0;
    din = 8'hA5;
    cyc = 0; nwe = 0; nbn = 0; we_hi = 0; w0 = -1; t_b0 = -1;
    prev_bn = byte_n; prev_we = 1'b0;
    while (cyc < 2500 && !(nwe == 2 && nbn == 2)) begin
      @(negedge clk32);
      cyc++;
      if (bus.ram_we) begin
        if (!prev_we && nwe < 2) begin
          we_t[nwe] = cyc;
          we_a[nwe] = int'(bus.ram_addr);
          we_d[nwe] = int'(bus.ram_di);
          nwe++;
        end
        we_hi++;
      end
      if (prev_bn && !byte_n) begin
        if (nbn == 0) t_b0 = cyc;
        nbn++;
      end
      if (!prev_bn && byte_n && w0 < 0) w0 = cyc - t_b0;
      prev_bn = byte_n; prev_we = bus.ram_we;
    end
    check("wr_count", nwe, 2);
    check("wr0_time", we_t[0], 8 * P0 + 1);
    check("wr0_addr", we_a[0], 2);
    check("wr0_data", we_d[0], 8'hA5);
    check("wr1_spacing", we_t[1] - we_t[0], 8 * P0);
    check("wr1_addr", we_a[1], 3);
    check("wr1_data", we_d[1], 8'hA5);
    check("wr_we_clocks", we_hi, 2);
    check("wr_byte_n_time", t_b0, 8 * P0 + 2);
    check("wr_pulse_w", w0, PW);
    check("wr_mem2", int'(mem[2]), 8'hA5);
    check("wr_mem3", int'(mem[3]), 8'hA5);

    // Reset in the middle of the second write's byte_n pulse
    repeat (4) @(negedge clk32);
    check("pulse_active", int'(byte_n), 0);
    reset = 1'b1;
    @(negedge clk32);
    check_reset_outputs("midpulse");
    we_hi = 0;
    repeat (3) begin
      @(negedge clk32);
      if (bus.ram_we) we_hi++;
    end
    reset = 1'b0;
    repeat (500) begin
      @(negedge clk32);
      if (bus.ram_we) we_hi++;
    end
    check("no_we_after_reset", we_hi, 0);

    // Motor drop three bits into the 0x52 byte, then resume
    set_buf8(64'hFFFF_5255_AA96_690F);
    start_read(2'd0, 13'd8);
    repeat (19 * P0 + 52) @(negedge clk32);
    mtr = 1'b0;
    @(negedge clk32);
    a_frz = bus.ram_addr;
    check("mtr_addr", int'(a_frz), 2);
    chg = 0; nbn = 0; nsl = 0;
    repeat (1000) begin
      @(negedge clk32);
      if (bus.ram_addr != a_frz) chg++;
      if (!byte_n) nbn++;
      if (!sync_n) nsl++;
    end
    check("mtr_addr_frozen", chg, 0);
    check("mtr_byte_n_high", nbn, 0);
    check("mtr_sync_n_high", nsl, 0);
    mtr = 1'b1;
    cyc = 0; nb = 0;
    prev_bn = byte_n;
    while (cyc < 1500 && nb == 0) begin
      @(negedge clk32);
      cyc++;
      if (prev_bn && !byte_n) begin
        nb = 1;
        dv[0] = dout;
      end
      prev_bn = byte_n;
    end
    check("resume_byte_seen", nb, 1);
    check("resume_dout", int'(dv[0]), 8'h52);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
